// File: rtl/car_lane_traffic_if.sv
// rtl/car_lane_traffic_if.sv - Frog position, game control and car lane outputs bundle
interface car_lane_traffic_if #(
    parameter int NUM_LANES = 4
);
    logic                    i_Game_Active;
    logic                    i_Level_Up;
    logic [9:0]              i_Frog_X;
    logic [9:0]              i_Frog_Y;
    logic                    o_Has_Collided;
    logic [10*NUM_LANES-1:0] o_Car_X;

    modport master (
        output i_Game_Active,
        output i_Level_Up,
        output i_Frog_X,
        output i_Frog_Y,
        input  o_Has_Collided,
        input  o_Car_X
    );

    modport slave (
        input  i_Game_Active,
        input  i_Level_Up,
        input  i_Frog_X,
        input  i_Frog_Y,
        output o_Has_Collided,
        output o_Car_X
    );
endinterface

// File: rtl/car_lane_traffic.sv
// rtl/car_lane_traffic.sv - Wrapping car lanes with level-scaled speed and frog collision strobe
module car_lane_traffic #(
    parameter int NUM_LANES       = 4,
    parameter int TILE_SIZE       = 32,
    parameter int CAR_WIDTH       = 64,
    parameter int H_VISIBLE_AREA  = 640,
    parameter int LANE_Y0         = 128,
    parameter int CAR_STEP        = 8,
    parameter int BASE_COUNT      = 3125000,
    parameter int SPEED_STEP      = 250000,
    parameter int MIN_COUNT       = 625000,
    parameter int COOLDOWN_CYCLES = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    car_lane_traffic_if.slave   bus
);
    localparam int CNT_W  = $clog2(BASE_COUNT + SPEED_STEP + 1);
    localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [CNT_W-1:0]  L_BASE    = CNT_W'(BASE_COUNT);
    localparam logic [CNT_W-1:0]  L_STEP    = CNT_W'(SPEED_STEP);
    localparam logic [CNT_W-1:0]  L_MIN     = CNT_W'(MIN_COUNT);
    localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(COOLDOWN_CYCLES);
    localparam logic [10:0]       H_W       = 11'(H_VISIBLE_AREA);
    localparam logic [10:0]       W_W       = 11'(CAR_WIDTH);
    localparam logic [10:0]       T_W       = 11'(TILE_SIZE);
    localparam logic [10:0]       S_W       = 11'(CAR_STEP);

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_ARMED,
        ST_HIT,
        ST_COOLDOWN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    limit_q, limit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COOL_W-1:0]   cool_q, cool_d;
    logic                collided_q, collided_d;
    logic [10:0]         car_x_q [NUM_LANES];
    logic [10:0]         car_x_d [NUM_LANES];
    logic [10:0]         car_init [NUM_LANES];
    logic [10:0]         moved_x [NUM_LANES];
    logic [NUM_LANES-1:0] lane_hit;
    logic [10*NUM_LANES-1:0] car_flat;

    logic [10:0]      frog_x;
    logic [10:0]      frog_y;
    logic             hit;
    logic             running;
    logic             tick;
    logic [CNT_W-1:0] limit_dec;

    assign frog_x = {1'b0, bus.i_Frog_X};
    assign frog_y = {1'b0, bus.i_Frog_Y};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [10:0] LANE_Y = 11'(LANE_Y0 + g * TILE_SIZE);
        logic [10:0] raw_d;
        logic [10:0] wrap_d;

        assign car_init[g] = 11'((g * H_VISIBLE_AREA / NUM_LANES) % H_VISIBLE_AREA);

        // Distance frog-minus-car modulo the screen width; the upper window catches overlap across the seam
        assign raw_d  = (frog_x >= car_x_q[g]) ? frog_x - car_x_q[g]
                                               : frog_x + H_W - car_x_q[g];
        assign wrap_d = (raw_d >= H_W) ? raw_d - H_W : raw_d;
        assign lane_hit[g] = (frog_y == LANE_Y) && ((wrap_d < W_W) || (wrap_d > H_W - T_W));

        if (g % 2 == 0) begin : g_right
            logic [10:0] sum;
            assign sum        = car_x_q[g] + S_W;
            assign moved_x[g] = (sum >= H_W) ? sum - H_W : sum;
        end else begin : g_left
            assign moved_x[g] = (car_x_q[g] < S_W) ? car_x_q[g] + H_W - S_W
                                                   : car_x_q[g] - S_W;
        end
    end

    assign hit       = |lane_hit;
    assign running   = (state_q == ST_ARMED) || (state_q == ST_COOLDOWN);
    assign tick      = running && (cnt_q >= limit_q);
    assign limit_dec = (limit_q >= L_MIN + L_STEP) ? limit_q - L_STEP : L_MIN;

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        cool_d  = cool_q;
        car_x_d = car_x_q;

        if (running) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            car_x_d = moved_x;
        end
        if (running && bus.i_Level_Up) begin
            limit_d = limit_dec;
        end

        case (state_q)
            ST_DISABLED: begin
                if (bus.i_Game_Active) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Collision overrides a coincident level-up and restores base speed
                if (hit && bus.i_Game_Active) begin
                    state_d = ST_HIT;
                    limit_d = L_BASE;
                end
            end
            ST_HIT: begin
                state_d = ST_COOLDOWN;
                cool_d  = COOL_INIT;
            end
            ST_COOLDOWN: begin
                cool_d = cool_q - 1'b1;
                if (cool_q <= 1) begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_DISABLED;
        endcase

        if (!bus.i_Game_Active) begin
            state_d = ST_DISABLED;
        end
    end

    assign collided_d = (state_d == ST_HIT);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= ST_DISABLED;
            limit_q    <= L_BASE;
            cnt_q      <= '0;
            cool_q     <= '0;
            collided_q <= 1'b0;
            car_x_q    <= car_init;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            cnt_q      <= cnt_d;
            cool_q     <= cool_d;
            collided_q <= collided_d;
            car_x_q    <= car_x_d;
        end
    end

    always_comb begin
        car_flat = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            car_flat[10*i +: 10] = car_x_q[i][9:0];
        end
    end

    assign bus.o_Car_X        = car_flat;
    assign bus.o_Has_Collided = collided_q;
endmodule
